// File: rtl/arb_pkg.sv
// Shared types, sizes and the circular priority pick for the eight-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t GRANT = 1'b1;

    // First set request bit scanning circularly from ptr; the scan runs backwards so the
    // smallest offset from ptr is the last (winning) assignment.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] idx;
        rr_pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + IDX_W'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/gnt_decoder.sv
// Enable-gated 3-to-8 one-hot decoder; all outputs low while enable is low.
module gnt_decoder
    import arb_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    assign onehot = en ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/rr_arbiter_eight.sv
// Eight-requester round-robin arbiter with locked grants.
// Build option RR_ARB_TIMEOUT_EN adds a hold counter that force-releases after MAX_HOLD cycles.
module rr_arbiter_eight
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             timeout_nxt;
    logic             hold_expired;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;

    // Held at zero in IDLE so the first GRANT cycle always starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= 8'd0;
        end else if (state == IDLE) begin
            hold_cnt <= 8'd0;
        end else begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign hold_expired = (hold_cnt == HOLD_LAST);
`else
    logic unused_max_hold;

    assign unused_max_hold = (MAX_HOLD != 0);
    assign hold_expired    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_idx <= idx_nxt;
            timeout <= timeout_nxt;
        end
    end

    // Release (voluntary or forced) always returns to IDLE before the next arbitration.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = gnt_idx;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    idx_nxt   = rr_pick(req, ptr);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[gnt_idx] || hold_expired) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = gnt_idx + IDX_W'(1);
                    timeout_nxt = req[gnt_idx] & hold_expired;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt_valid = (state == GRANT);

    gnt_decoder u_gnt_decoder (
        .en     (gnt_valid),
        .idx    (gnt_idx),
        .onehot (gnt)
    );

endmodule
